add32_nibble_seq: RTL and testbench
===================================

Name: add32_nibble_seq

Overview:
- Multi-cycle 32-bit adder. Shares one 4-bit ripple-carry slice (existing rca4, combinational) across the operand, one nibble per clock, LSB nibble first.
- Trades latency (8 cycles) for one slice of adder hardware. Sits beside the full 32-bit RCA as an area-reduced alternative with a start/done handshake.
- Carry between nibbles is held in a flip-flop; operands are held in shift registers.

Parameters:
- none (operand width fixed at 32 bits, slice width 4 bits, 8 slice passes)

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request a new add; sampled only in IDLE
- a  input  32  operand A; captured on the accepting edge
- b  input  32  operand B; captured on the accepting edge
- ci  input  1  carry-in; captured on the accepting edge
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse, result valid
- s  output  32  registered sum; holds until the next completion
- co  output  1  registered carry-out; holds until the next completion

Behaviour:
- States: IDLE, RUN, DONE (2-bit encoding). 3-bit nibble counter cnt.
- Reset (reset_n low, asynchronous):
  - state=IDLE, cnt=0.
  - Operand shift registers and carry flip-flop cleared.
  - s=0, co=0, busy=0, done=0.
- IDLE:
  - On an edge with start=1: load sa<=a, sb<=b, carry<=ci, sum shift register<=0, cnt<=0, go RUN.
  - start=0: stay.
- RUN, each edge:
  - Slice inputs are sa[3:0], sb[3:0], carry.
  - Slice sum nibble shifts into sum_sr[31:28]; sum_sr shifts right by 4.
  - sa and sb shift right by 4. carry<=slice co. cnt<=cnt+1.
  - When cnt==7 on that edge: go DONE and load outputs at the same edge:
    - s<=final sum_sr value, including the nibble shifted in at this edge.
    - co<=slice co of this pass.
- DONE:
  - done=1 for exactly one cycle, busy=1.
  - Next edge: go IDLE unconditionally. start in DONE is ignored and not queued.
- Latency:
  - start accepted at edge E0; nibble k computed on edge E(k+1), k=0..7.
  - State=DONE and s/co valid after E8; done high during cycle E8..E9.
  - Next start is accepted at E10 at the earliest.
- start while busy: ignored. a, b and ci may change freely after E0 without affecting the result.
- s/co change only at the completion edge. They are never partially updated during RUN.
- Arithmetic: {co,s} = a + b + ci, modulo 2^33. No signed interpretation.
- cnt wrap: cnt rolls 7->0 at completion. It is only meaningful in RUN.
- Reset mid-operation: abandons the add immediately (asynchronous). s/co return to 0, done never pulses, state=IDLE.
- busy is a combinational decode of state, glitch-free because state is registered. done is decoded from state==DONE.

Test Plan:
- Reset, then a=0x12345678, b=0x87654321, ci=0, start pulse at E0:
  - busy=1 from E0, done pulses after E8.
  - s=0x99999999, co=0.
  - s stays 0 during RUN.
- a=0xFFFFFFFF, b=0x00000000, ci=1:
  - Carry ripples through all 8 passes.
  - s=0x00000000, co=1 after E8.
- a=0x80000000, b=0x80000000, ci=0:
  - s=0x00000000, co=1.
  - Then a=0x0000000F, b=0x00000001, ci=1: s=0x00000011, co=0 (carry flip-flop correctly reloaded).
- Hold start=1 continuously with a and b changing every cycle:
  - Adds are accepted only at E0, E10, E20...
  - Each result matches the operands present at its accept edge.
  - done pulses at E8, E18, ... for exactly one cycle.
- Start a=0xDEADBEEF, b=0x11111111, drop reset_n at E4 for one cycle:
  - s=0, co=0, busy=0 immediately, no done pulse.
  - A new add then completes correctly: 0xDEADBEEF+0x11111111 gives s=0xEFBED000, co=0.
- Random regression of 1000 vectors against the 33-bit reference sum {co,s}=a+b+ci, with random start gaps (0..5 idle cycles).

Source files
------------

// File: rtl/add32_nibble_seq.sv
// Multi-cycle 32-bit adder: one shared 4-bit ripple-carry slice, one nibble per clock,
// LSB nibble first, with a start/busy/done handshake. Also holds the rca4 slice.

module rca4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c;

  assign c[0] = ci;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_fa
      assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign co = c[4];
endmodule

module add32_nibble_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic        busy,
  output logic        done,
  output logic [31:0] s,
  output logic        co
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] sa_q, sa_d;
  logic [31:0] sb_q, sb_d;
  logic        carry_q, carry_d;
  logic [31:0] sum_sr_q, sum_sr_d;
  logic [31:0] s_q, s_d;
  logic        co_q, co_d;

  logic [3:0]  slice_s;
  logic        slice_co;

  rca4 u_slice (
    .a  (sa_q[3:0]),
    .b  (sb_q[3:0]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      sa_q     <= 32'd0;
      sb_q     <= 32'd0;
      carry_q  <= 1'b0;
      sum_sr_q <= 32'd0;
      s_q      <= 32'd0;
      co_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      carry_q  <= carry_d;
      sum_sr_q <= sum_sr_d;
      s_q      <= s_d;
      co_q     <= co_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    carry_d  = carry_q;
    sum_sr_d = sum_sr_q;
    s_d      = s_q;
    co_d     = co_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sa_d     = a;
          sb_d     = b;
          carry_d  = ci;
          sum_sr_d = 32'd0;
          cnt_d    = 3'd0;
          state_d  = RUN;
        end
      end
      RUN: begin
        sum_sr_d = {slice_s, sum_sr_q[31:4]};
        sa_d     = {4'd0, sa_q[31:4]};
        sb_d     = {4'd0, sb_q[31:4]};
        carry_d  = slice_co;
        cnt_d    = cnt_q + 3'd1;
        // Last pass: publish the sum including the nibble produced on this edge.
        if (cnt_q == 3'd7) begin
          s_d     = {slice_s, sum_sr_q[31:4]};
          co_d    = slice_co;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign co   = co_q;
endmodule

// File: tb/tb_add32_nibble_seq.sv
// Bench for add32_nibble_seq: timing/arithmetic reference model checked every cycle,
// plus directed adds with hand-computed sums.

module tb_add32_nibble_seq;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        ci = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] s;
  logic        co;

  int n_checks = 0;
  int n_pass   = 0;
  int n_txn    = 0;

  add32_nibble_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .ci      (ci),
    .busy    (busy),
    .done    (done),
    .s       (s),
    .co      (co)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [32:0] got, input logic [32:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Reference model: phase = edges since the accepting edge, -1 when idle.
  int          m_phase = -1;
  logic [32:0] m_res   = 33'd0;
  logic [31:0] m_s     = 32'd0;
  logic        m_co    = 1'b0;
  logic [31:0] m_a = 32'd0, m_b = 32'd0;
  logic        m_ci = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase <= -1;
      m_s     <= 32'd0;
      m_co    <= 1'b0;
    end else if (m_phase < 0) begin
      if (start) begin
        m_phase <= 0;
        m_res   <= {1'b0, a} + {1'b0, b} + {32'd0, ci};
        m_a     <= a;
        m_b     <= b;
        m_ci    <= ci;
      end
    end else if (m_phase == 8) begin
      m_phase <= -1;
    end else begin
      m_phase <= m_phase + 1;
      if (m_phase == 7) {m_co, m_s} <= m_res;
    end
  end

  logic chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {32'd0, busy}, {32'd0, (m_phase >= 0)});
      chk("done", {32'd0, done}, {32'd0, (m_phase == 8)});
      chk("s",    {1'b0, s},     {1'b0, m_s});
      chk("co",   {32'd0, co},   {32'd0, m_co});
      if (m_phase == 8) begin
        n_txn++;
        $display("txn %0d: a=%h b=%h ci=%b -> s=%h co=%b", n_txn, m_a, m_b, m_ci, s, co);
      end
    end
  end

  // Launch one add, scramble operands after the accept edge, wait for done, check literals.
  task automatic run_add(input logic [31:0] ta, input logic [31:0] tb, input logic tci,
                         input logic [31:0] exp_s, input logic exp_co, input string name);
    bit seen = 0;
    @(posedge clk); #2;
    start = 1'b1; a = ta; b = tb; ci = tci;
    @(posedge clk); #2;
    start = 1'b0; a = $urandom; b = $urandom; ci = 1'($urandom);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk({name, "_done_seen"}, {32'd0, seen}, 33'd1);
    chk({name, "_s"},  {1'b0, s},   {1'b0, exp_s});
    chk({name, "_co"}, {32'd0, co}, {32'd0, exp_co});
  endtask

  initial begin
    int          ndone;
    logic [31:0] ra, rb;
    logic        rci;
    logic [32:0] rsum;

    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_s",    {1'b0, s},     33'd0);
    chk("reset_busy", {32'd0, busy}, 33'd0);
    @(posedge clk); #2;
    reset_n = 1'b1;

    run_add(32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, "basic");
    run_add(32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, "ripple");
    run_add(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, "msb_carry");
    run_add(32'h0000000F, 32'h00000001, 1'b1, 32'h00000011, 1'b0, "carry_reload");

    // start held high: accepts every 10 edges, three done pulses in 30 edges.
    ndone = 0;
    @(posedge clk); #2;
    start = 1'b1; a = $urandom; b = $urandom; ci = 1'($urandom);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) ndone++;
      a = $urandom; b = $urandom; ci = 1'($urandom);
    end
    start = 1'b0;
    chk("held_start_done_count", {1'b0, 32'(ndone)}, 33'd3);

    // Reset dropped at E4 abandons the add.
    @(posedge clk); #2;
    start = 1'b1; a = 32'hDEADBEEF; b = 32'h11111111; ci = 1'b0;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_s",    {1'b0, s},     33'd0);
    chk("midreset_co",   {32'd0, co},   33'd0);
    chk("midreset_busy", {32'd0, busy}, 33'd0);
    chk("midreset_done", {32'd0, done}, 33'd0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    run_add(32'hDEADBEEF, 32'h11111111, 1'b0, 32'hEFBED000, 1'b0, "after_reset");

    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      ra = $urandom; rb = $urandom; rci = 1'($urandom);
      rsum = {1'b0, ra} + {1'b0, rb} + {32'd0, rci};
      run_add(ra, rb, rci, rsum[31:0], rsum[32], "random");
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
